// File: rtl/coeff_pkg.sv
// coeff_pkg
// Shared constants and helpers for the convolver coefficient store.
//   COEFF_IN_W      default width of bus-side coefficient words
//   COEFF_OUT_W     default width of coefficients seen by the convolver
//   COEFF_NUM_TAPS  default number of taps
//   sat_narrow()    signed-saturating narrow from in_w to out_w bits; also
//                   used by the convolver datapath model, so widths are
//                   run-time arguments (both limited to 64 bits).
package coeff_pkg;

    localparam int COEFF_IN_W     = 16;
    localparam int COEFF_OUT_W    = 12;
    localparam int COEFF_NUM_TAPS = 3;

    // Result carries the narrowed value in its low out_w bits, upper bits zero.
    function automatic logic [63:0] sat_narrow(input logic [63:0] value,
                                               input int          in_w,
                                               input int          out_w);
        logic signed [63:0] sval;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        logic        [63:0] keep_mask;
        logic        [63:0] result;
        // Sign-extend the in_w-bit input to the full 64 bits.
        sval      = signed'(value << (64 - in_w)) >>> (64 - in_w);
        max_v     = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v     = -(64'sd1 <<< (out_w - 1));
        // A 64-bit shift yields zero, so out_w == 64 still gives all ones.
        keep_mask = (64'd1 << out_w) - 64'd1;
        if (sval > max_v) begin
            result = max_v;
        end else if (sval < min_v) begin
            result = min_v;
        end else begin
            result = sval;
        end
        return result & keep_mask;
    endfunction

endpackage

// File: rtl/coeff_narrow.sv
// coeff_narrow
// Combinational IN_W-to-OUT_W narrowing of one coefficient.
//   din   in   IN_W   bus-side coefficient
//   dout  out  OUT_W  SAT_MODE=0: low OUT_W bits of din
//                     SAT_MODE=1: din treated as signed, clamped to OUT_W range
module coeff_narrow
    import coeff_pkg::*;
#(
    parameter int IN_W     = COEFF_IN_W,
    parameter int OUT_W    = COEFF_OUT_W,
    parameter int SAT_MODE = 0
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout
);

    logic [63:0] sat_full;
    logic        unused_sat_bits;

    always_comb begin
        sat_full = sat_narrow(64'(din), IN_W, OUT_W);
        if (SAT_MODE != 0) begin
            dout = sat_full[OUT_W-1:0];
        end else begin
            dout = din[OUT_W-1:0];
        end
    end

    // Only the low OUT_W bits of the helper result are meaningful.
    assign unused_sat_bits = ^sat_full;

endmodule

// File: rtl/coeff_bank.sv
// coeff_bank
// Double-buffered coefficient store. Bus writes go to a shadow bank; the
// convolver only sees the active bank, which is loaded atomically on a commit.
// A commit requested while the convolver is busy is held until it goes idle.
//   clk             in   system clock
//   rst             in   synchronous active-high reset
//   coeff_ld        in   write coeff_in to shadow[coeff_sel]
//   coeff_sel       in   shadow write index
//   coeff_in        in   write data
//   commit_req      in   request shadow-to-active transfer
//   conv_busy       in   convolver busy, active bank must not change
//   rd_sel          in   shadow readback index
//   rd_data         out  registered shadow readback (0 for invalid index)
//   coeff_out       out  active bank, tap k at [k*OUT_W +: OUT_W]
//   shadow_full     out  every tap written since the last commit
//   commit_pending  out  commit accepted but waiting for conv_busy to drop
//   commit_done     out  pulse in the first cycle the new bank is visible
//   sel_err         out  pulse after a write with an out-of-range select
module coeff_bank
    import coeff_pkg::*;
#(
    parameter int NUM_TAPS = COEFF_NUM_TAPS,
    parameter int IN_W     = COEFF_IN_W,
    parameter int OUT_W    = COEFF_OUT_W,
    parameter int SAT_MODE = 0,
    parameter int SEL_W    = $clog2(NUM_TAPS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      coeff_ld,
    input  logic [SEL_W-1:0]          coeff_sel,
    input  logic [IN_W-1:0]           coeff_in,
    input  logic                      commit_req,
    input  logic                      conv_busy,
    input  logic [SEL_W-1:0]          rd_sel,
    output logic [IN_W-1:0]           rd_data,
    output logic [NUM_TAPS*OUT_W-1:0] coeff_out,
    output logic                      shadow_full,
    output logic                      commit_pending,
    output logic                      commit_done,
    output logic                      sel_err
);

    // One extra bit so NUM_TAPS itself is representable for the range check.
    localparam logic [SEL_W:0] TAPS_LIMIT = (SEL_W + 1)'(NUM_TAPS);

    logic [IN_W-1:0]           shadow      [NUM_TAPS];
    logic [IN_W-1:0]           next_shadow [NUM_TAPS];
    logic [NUM_TAPS-1:0]       written;
    logic [NUM_TAPS-1:0]       next_written;
    logic [NUM_TAPS*OUT_W-1:0] narrowed;
    logic [IN_W-1:0]           rd_next;
    logic                      sel_ok;
    logic                      rd_ok;
    logic                      do_commit;

    assign sel_ok    = ({1'b0, coeff_sel} < TAPS_LIMIT);
    assign rd_ok     = ({1'b0, rd_sel} < TAPS_LIMIT);
    assign do_commit = (commit_req | commit_pending) & ~conv_busy;

    // Shadow contents including this cycle's write, so a tap written in the
    // same cycle as a commit is part of that commit.
    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            next_shadow[k]  = shadow[k];
            next_written[k] = written[k];
            if (coeff_ld && sel_ok && (coeff_sel == SEL_W'(k))) begin
                next_shadow[k]  = coeff_in;
                next_written[k] = 1'b1;
            end
        end
    end

    always_comb begin
        rd_next = '0;
        if (rd_ok) begin
            rd_next = shadow[rd_sel];
        end
    end

    for (genvar g = 0; g < NUM_TAPS; g++) begin : g_narrow
        coeff_narrow #(
            .IN_W     (IN_W),
            .OUT_W    (OUT_W),
            .SAT_MODE (SAT_MODE)
        ) u_narrow (
            .din  (next_shadow[g]),
            .dout (narrowed[g*OUT_W +: OUT_W])
        );
    end

    assign shadow_full = &written;

    // Readback samples the shadow before this cycle's write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                shadow[k] <= '0;
            end
            written        <= '0;
            coeff_out      <= '0;
            rd_data        <= '0;
            commit_pending <= 1'b0;
            commit_done    <= 1'b0;
            sel_err        <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                shadow[k] <= next_shadow[k];
            end
            written <= do_commit ? '0 : next_written;
            if (do_commit) begin
                coeff_out <= narrowed;
            end
            rd_data        <= rd_next;
            commit_pending <= ~do_commit & (commit_pending | (commit_req & conv_busy));
            commit_done    <= do_commit;
            sel_err        <= coeff_ld & ~sel_ok;
        end
    end

endmodule

// File: tb/tb_coeff_bank.sv
// tb_coeff_bank
// Directed bench for coeff_bank. Three instances share one stimulus set:
// a 3-tap truncating bank, and 4-tap banks with and without saturation.
module tb_coeff_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        coeff_ld;
    logic [1:0]  coeff_sel;
    logic [15:0] coeff_in;
    logic        commit_req;
    logic        conv_busy;
    logic [1:0]  rd_sel;

    logic [15:0] rd_data3,  rd_data4s, rd_data4z;
    logic [35:0] out3;
    logic [47:0] out4s, out4z;
    logic        full3, full4s, full4z;
    logic        pend3, pend4s, pend4z;
    logic        done3, done4s, done4z;
    logic        err3,  err4s,  err4z;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    coeff_bank #(.NUM_TAPS(3), .IN_W(16), .OUT_W(12), .SAT_MODE(0)) dut3 (
        .clk(clk), .rst(rst), .coeff_ld(coeff_ld), .coeff_sel(coeff_sel),
        .coeff_in(coeff_in), .commit_req(commit_req), .conv_busy(conv_busy),
        .rd_sel(rd_sel), .rd_data(rd_data3), .coeff_out(out3),
        .shadow_full(full3), .commit_pending(pend3), .commit_done(done3),
        .sel_err(err3)
    );

    coeff_bank #(.NUM_TAPS(4), .IN_W(16), .OUT_W(12), .SAT_MODE(1)) dut4s (
        .clk(clk), .rst(rst), .coeff_ld(coeff_ld), .coeff_sel(coeff_sel),
        .coeff_in(coeff_in), .commit_req(commit_req), .conv_busy(conv_busy),
        .rd_sel(rd_sel), .rd_data(rd_data4s), .coeff_out(out4s),
        .shadow_full(full4s), .commit_pending(pend4s), .commit_done(done4s),
        .sel_err(err4s)
    );

    coeff_bank #(.NUM_TAPS(4), .IN_W(16), .OUT_W(12), .SAT_MODE(0)) dut4z (
        .clk(clk), .rst(rst), .coeff_ld(coeff_ld), .coeff_sel(coeff_sel),
        .coeff_in(coeff_in), .commit_req(commit_req), .conv_busy(conv_busy),
        .rd_sel(rd_sel), .rd_data(rd_data4z), .coeff_out(out4z),
        .shadow_full(full4z), .commit_pending(pend4z), .commit_done(done4z),
        .sel_err(err4z)
    );

    typedef struct {
        logic        rst;
        logic        ld;
        logic [1:0]  sel;
        logic [15:0] din;
        logic        req;
        logic        busy;
        logic [1:0]  rsel;
        logic [35:0] e_out;
        logic [15:0] e_rd;
        logic        e_full;
        logic        e_pend;
        logic        e_done;
        logic        e_err;
    } vec_t;

    vec_t vecs [11];

    function automatic vec_t mk(input logic r, input logic ld, input logic [1:0] sel,
                                input logic [15:0] din, input logic req, input logic busy,
                                input logic [1:0] rsel, input logic [35:0] e_out,
                                input logic [15:0] e_rd, input logic e_full,
                                input logic e_pend, input logic e_done, input logic e_err);
        vec_t v;
        v.rst = r;     v.ld = ld;       v.sel = sel;       v.din = din;
        v.req = req;   v.busy = busy;   v.rsel = rsel;     v.e_out = e_out;
        v.e_rd = e_rd; v.e_full = e_full; v.e_pend = e_pend;
        v.e_done = e_done; v.e_err = e_err;
        return v;
    endfunction

    // Drive one cycle of inputs, then wait until just after the clock edge.
    task automatic applyStimulus(input logic r, input logic ld, input logic [1:0] sel,
                                 input logic [15:0] din, input logic req,
                                 input logic busy, input logic [1:0] rsel);
        rst        = r;
        coeff_ld   = ld;
        coeff_sel  = sel;
        coeff_in   = din;
        commit_req = req;
        conv_busy  = busy;
        rd_sel     = rsel;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    initial begin
        int dones;

        // Reset, three writes with readback, select error while full,
        // commit, invalid readback, then a same-cycle write+commit.
        vecs[0]  = mk(1, 0, 0, 16'h0000, 0, 0, 0, 36'h0,         16'h0000, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 0, 16'h0123, 0, 0, 0, 36'h0,         16'h0000, 0, 0, 0, 0);
        vecs[2]  = mk(0, 1, 1, 16'h0456, 0, 0, 0, 36'h0,         16'h0123, 0, 0, 0, 0);
        vecs[3]  = mk(0, 1, 2, 16'h0789, 0, 0, 1, 36'h0,         16'h0456, 1, 0, 0, 0);
        vecs[4]  = mk(0, 1, 3, 16'h0FFF, 0, 0, 2, 36'h0,         16'h0789, 1, 0, 0, 1);
        vecs[5]  = mk(0, 0, 0, 16'h0000, 1, 0, 0, 36'h789456123, 16'h0123, 0, 0, 1, 0);
        vecs[6]  = mk(0, 0, 0, 16'h0000, 0, 0, 3, 36'h789456123, 16'h0000, 0, 0, 0, 0);
        vecs[7]  = mk(0, 1, 0, 16'h0AAA, 0, 0, 0, 36'h789456123, 16'h0123, 0, 0, 0, 0);
        vecs[8]  = mk(0, 1, 1, 16'h0BBB, 0, 0, 1, 36'h789456123, 16'h0456, 0, 0, 0, 0);
        vecs[9]  = mk(0, 1, 2, 16'h0055, 1, 0, 2, 36'h055BBBAAA, 16'h0789, 0, 0, 1, 0);
        vecs[10] = mk(0, 0, 0, 16'h0000, 0, 0, 2, 36'h055BBBAAA, 16'h0055, 0, 0, 0, 0);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].ld, vecs[i].sel, vecs[i].din,
                          vecs[i].req, vecs[i].busy, vecs[i].rsel);
            checkOutput($sformatf("v%0d.coeff_out", i), 64'(out3), 64'(vecs[i].e_out));
            checkOutput($sformatf("v%0d.rd_data", i), 64'(rd_data3), 64'(vecs[i].e_rd));
            checkOutput($sformatf("v%0d.shadow_full", i), 64'(full3), 64'(vecs[i].e_full));
            checkOutput($sformatf("v%0d.commit_pending", i), 64'(pend3), 64'(vecs[i].e_pend));
            checkOutput($sformatf("v%0d.commit_done", i), 64'(done3), 64'(vecs[i].e_done));
            checkOutput($sformatf("v%0d.sel_err", i), 64'(err3), 64'(vecs[i].e_err));
        end

        // Deferred commit: busy for 5 cycles, request in cycle 1, an absorbed
        // extra request in cycle 4, tap1 rewritten in cycle 3.
        dones = 0;
        for (int c = 1; c <= 5; c++) begin
            applyStimulus(0, (c == 3), 2'd1, 16'h0ABC, (c == 1 || c == 4), 1, 0);
            dones += int'(done3);
            checkOutput($sformatf("defer.c%0d.coeff_out", c), 64'(out3), 64'h055BBBAAA);
            checkOutput($sformatf("defer.c%0d.pending", c), 64'(pend3), 64'd1);
        end
        applyStimulus(0, 0, 0, 16'h0000, 0, 0, 0);
        dones += int'(done3);
        checkOutput("defer.commit.coeff_out", 64'(out3), 64'h055ABCAAA);
        checkOutput("defer.commit.done", 64'(done3), 64'd1);
        checkOutput("defer.commit.pending", 64'(pend3), 64'd0);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, 0, 0, 16'h0000, 0, 0, 0);
            dones += int'(done3);
        end
        checkOutput("defer.done_count", 64'(dones), 64'd1);

        // Reset while a commit is pending discards it.
        applyStimulus(0, 0, 0, 16'h0000, 1, 1, 0);
        checkOutput("rst_mid.pending_set", 64'(pend3), 64'd1);
        applyStimulus(1, 0, 0, 16'h0000, 0, 1, 0);
        checkOutput("rst_mid.coeff_out", 64'(out3), 64'd0);
        checkOutput("rst_mid.rd_data", 64'(rd_data3), 64'd0);
        checkOutput("rst_mid.full", 64'(full3), 64'd0);
        checkOutput("rst_mid.pending", 64'(pend3), 64'd0);
        checkOutput("rst_mid.done", 64'(done3), 64'd0);
        checkOutput("rst_mid.sel_err", 64'(err3), 64'd0);
        dones = 0;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(0, 0, 0, 16'h0000, 0, 0, 0);
            dones += int'(done3);
        end
        checkOutput("rst_mid.no_done", 64'(dones), 64'd0);
        checkOutput("rst_mid.coeff_after", 64'(out3), 64'd0);

        // Saturation vs truncation on the 4-tap banks, two value sets.
        applyStimulus(1, 0, 0, 16'h0000, 0, 0, 0);
        applyStimulus(0, 1, 0, 16'h7FFF, 0, 0, 0);
        applyStimulus(0, 1, 1, 16'h8000, 0, 0, 0);
        applyStimulus(0, 1, 2, 16'h07FF, 0, 0, 0);
        applyStimulus(0, 1, 3, 16'hF800, 0, 0, 0);
        checkOutput("sat1.full_s", 64'(full4s), 64'd1);
        checkOutput("sat1.full_z", 64'(full4z), 64'd1);
        checkOutput("sat1.err_s", 64'(err4s), 64'd0);
        applyStimulus(0, 0, 0, 16'h0000, 1, 0, 3);
        checkOutput("sat1.out_s", 64'(out4s), 64'h8007FF8007FF);
        checkOutput("sat1.out_z", 64'(out4z), 64'h8007FF000FFF);
        checkOutput("sat1.done_s", 64'(done4s), 64'd1);
        checkOutput("sat1.done_z", 64'(done4z), 64'd1);
        checkOutput("sat1.rd_s", 64'(rd_data4s), 64'hF800);
        checkOutput("sat1.rd_z", 64'(rd_data4z), 64'hF800);

        applyStimulus(0, 1, 0, 16'h0800, 0, 0, 0);
        applyStimulus(0, 1, 1, 16'hF7FF, 0, 0, 0);
        applyStimulus(0, 1, 2, 16'hFFFF, 0, 0, 0);
        applyStimulus(0, 1, 3, 16'h0000, 1, 0, 0);
        checkOutput("sat2.out_s", 64'(out4s), 64'h000FFF8007FF);
        checkOutput("sat2.out_z", 64'(out4z), 64'h000FFF7FF800);
        checkOutput("sat2.pending_s", 64'(pend4s), 64'd0);
        checkOutput("sat2.pending_z", 64'(pend4z), 64'd0);
        checkOutput("sat2.err_z", 64'(err4z), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
